inference_sequencer: RTL

- Top-level controller for the CNN inference path. It sits downstream of the UART byte router and upstream of the UART transmitter.
- Consumes the "image loaded" event and the command bytes 0xCC/0xCD. Sequences the NUM_STAGES compute stages (conv1, pool1, conv2, pool2, dense, argmax) with start/done handshakes.
- Reports the predicted digit, or a status code, as one byte over a shared UART TX.

---
 rtl/cnn_pkg.sv | 27 ++
 rtl/stage_watchdog.sv | 29 ++
 rtl/inference_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants for the CNN inference path: command bytes, status codes,
// stage indices and the sequencer state type.
package cnn_pkg;

    localparam logic [7:0] CMD_RUN  = 8'hCC;
    localparam logic [7:0] CMD_READ = 8'hCD;
    localparam logic [7:0] NAK_BYTE = 8'hEE;
    localparam logic [7:0] ERR_BYTE = 8'hEF;

    localparam int unsigned STG_CONV1  = 0;
    localparam int unsigned STG_POOL1  = 1;
    localparam int unsigned STG_CONV2  = 2;
    localparam int unsigned STG_POOL2  = 3;
    localparam int unsigned STG_DENSE  = 4;
    localparam int unsigned STG_ARGMAX = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_LATCH,
        S_TX_SEND,
        S_TX_WAIT_HI,
        S_TX_WAIT_LO
    } state_t;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage run-time limiter: counts enabled cycles after a clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES.
module stage_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned    CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TERM = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  FULL = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    // Fires on the enabled cycle whose increment brings the count to TIMEOUT_CYCLES.
    assign expired = enable && (count == TERM);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != FULL)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/inference_sequencer.sv
// Inference controller: runs the compute stages in order, then reports the
// predicted digit or a status byte through the shared UART transmitter.
module inference_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 6,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter bit          AUTO_RUN       = 1'b1,
    parameter logic [7:0]  NAK_CODE       = NAK_BYTE,
    parameter logic [7:0]  ERR_CODE       = ERR_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  weights_loaded,
    input  logic                  image_loaded,
    input  logic [7:0]            cmd_data,
    input  logic                  cmd_valid,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic [3:0]            result_digit,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic                  cmd_dropped,
    output logic [3:0]            last_result
);
    localparam int unsigned   KW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [KW-1:0] LAST_STAGE = KW'(NUM_STAGES - 1);

    state_t        state, state_nxt;
    logic [KW-1:0] k, k_nxt;
    logic          image_valid, has_result;
    logic          tx_load, latch_en, start_taken;
    logic [7:0]    tx_byte_nxt;
    logic          is_run, is_read, wd_expired;

    assign is_run  = cmd_valid && (cmd_data == CMD_RUN);
    assign is_read = cmd_valid && (cmd_data == CMD_READ);

    assign busy        = (state != S_IDLE);
    assign stage_start = (state == S_START) ? (NUM_STAGES'(1) << k) : '0;

    stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == S_START),
        .enable (state == S_WAIT_DONE),
        .expired(wd_expired)
    );

    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        tx_load     = 1'b0;
        tx_byte_nxt = tx_data;
        latch_en    = 1'b0;
        start_taken = 1'b0;
        tx_start    = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_read) begin
                    tx_load     = 1'b1;
                    tx_byte_nxt = has_result ? {4'h0, last_result} : NAK_CODE;
                    state_nxt   = S_TX_SEND;
                end else if (image_valid && weights_loaded && (AUTO_RUN || is_run)) begin
                    start_taken = 1'b1;
                    k_nxt       = '0;
                    state_nxt   = S_START;
                end else if (is_run) begin
                    tx_load     = 1'b1;
                    tx_byte_nxt = NAK_CODE;
                    state_nxt   = S_TX_SEND;
                end
            end
            S_START: state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                // A done pulse in the timeout cycle still counts as completion.
                if (stage_done[k]) begin
                    if (k == LAST_STAGE) begin
                        state_nxt = S_LATCH;
                    end else begin
                        k_nxt     = k + 1'b1;
                        state_nxt = S_START;
                    end
                end else if (wd_expired) begin
                    tx_load     = 1'b1;
                    tx_byte_nxt = ERR_CODE;
                    k_nxt       = '0;
                    state_nxt   = S_TX_SEND;
                end
            end
            S_LATCH: begin
                latch_en    = 1'b1;
                tx_load     = 1'b1;
                tx_byte_nxt = {4'h0, result_digit};
                k_nxt       = '0;
                state_nxt   = S_TX_SEND;
            end
            S_TX_SEND: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = S_TX_WAIT_HI;
                end
            end
            S_TX_WAIT_HI: state_nxt = S_TX_WAIT_LO;
            S_TX_WAIT_LO: begin
                if (!tx_busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            k           <= '0;
            image_valid <= 1'b0;
            has_result  <= 1'b0;
            last_result <= '0;
            tx_data     <= '0;
            cmd_dropped <= 1'b0;
        end else begin
            state       <= state_nxt;
            k           <= k_nxt;
            cmd_dropped <= cmd_valid && (state != S_IDLE);
            if (image_loaded) begin
                image_valid <= 1'b1;
            end else if (start_taken) begin
                image_valid <= 1'b0;
            end
            if (latch_en) begin
                last_result <= result_digit;
                has_result  <= 1'b1;
            end
            if (tx_load) begin
                tx_data <= tx_byte_nxt;
            end
        end
    end

endmodule
